// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, ALU op encodings and control bundle for the RV32I core
package core_pkg;

    localparam int XLEN    = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 4;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    // Decoded control that travels with an instruction from ID into EX.
    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               branch;
        logic               jump;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// rtl/id_ex_stage_reg_hazard_detect.sv - combinational load-use and branch-flush hazard logic
//   in : hold, ex_branch_taken, EX slot (ex_valid, ex_mem_read, ex_rd),
//        ID slot (id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2)
//   out: load_use, pc_write, if_id_write, if_id_flush
module hazard_detect
    import core_pkg::*;
(
    input  logic             hold,
    input  logic             ex_branch_taken,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    output logic             load_use,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush
);

    logic rs1_hit;
    logic rs2_hit;
    logic stall;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                      && (rs1_hit || rs2_hit);

    // A taken branch squashes the dependent instruction, so the stall is dropped.
    assign stall       = load_use && !ex_branch_taken;
    assign pc_write    = !hold && !stall;
    assign if_id_write = !hold && !stall;
    assign if_id_flush = ex_branch_taken && !hold;

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use stall, branch flush and event counters
//   in : clk, reset (sync, active-high), hold, ex_branch_taken, id_* decoded instruction
//   out: ex_* registered instruction, pc_write, if_id_write, if_id_flush,
//        stall_count, flush_count (saturating)
module id_ex_stage_reg #(
    parameter int XLEN    = core_pkg::XLEN,
    parameter int REG_W   = core_pkg::REG_W,
    parameter int ALUOP_W = core_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               ex_branch_taken,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic               id_branch,
    input  logic               id_jump,
    input  logic [ALUOP_W-1:0] id_alu_op,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [REG_W-1:0]   ex_rs1,
    output logic [REG_W-1:0]   ex_rs2,
    output logic [REG_W-1:0]   ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               if_id_flush,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);

    core_pkg::ctrl_t id_ctrl;
    core_pkg::ctrl_t ex_ctrl;
    logic            load_use;

    // Control is qualified by id_valid so an empty slot can never write state.
    always_comb begin
        id_ctrl = core_pkg::CTRL_BUBBLE;
        if (id_valid) begin
            id_ctrl.reg_write  = id_reg_write;
            id_ctrl.mem_read   = id_mem_read;
            id_ctrl.mem_write  = id_mem_write;
            id_ctrl.mem_to_reg = id_mem_to_reg;
            id_ctrl.alu_src    = id_alu_src;
            id_ctrl.branch     = id_branch;
            id_ctrl.jump       = id_jump;
            id_ctrl.alu_op     = id_alu_op;
        end
    end

    hazard_detect u_hazard_detect (
        .hold            (hold),
        .ex_branch_taken (ex_branch_taken),
        .ex_valid        (ex_valid),
        .ex_mem_read     (ex_ctrl.mem_read),
        .ex_rd           (ex_rd),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .load_use        (load_use),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= core_pkg::CTRL_BUBBLE;
            stall_count <= '0;
            flush_count <= '0;
        end else if (!hold) begin
            if (ex_branch_taken || load_use) begin
                // Bubble: data fields are cleared too so EX never sees stale operands.
                ex_valid    <= 1'b0;
                ex_pc       <= '0;
                ex_rs1_data <= '0;
                ex_rs2_data <= '0;
                ex_imm      <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_rd       <= '0;
                ex_ctrl     <= core_pkg::CTRL_BUBBLE;
                // Flush outranks the stall: the dependent instruction is on the wrong path.
                if (ex_branch_taken) begin
                    if (flush_count != '1) flush_count <= flush_count + 1'b1;
                end else begin
                    if (stall_count != '1) stall_count <= stall_count + 1'b1;
                end
            end else begin
                ex_valid    <= id_valid;
                ex_pc       <= id_pc;
                ex_rs1_data <= id_rs1_data;
                ex_rs2_data <= id_rs2_data;
                ex_imm      <= id_imm;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
                ex_ctrl     <= id_ctrl;
            end
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_jump       = ex_ctrl.jump;
    assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;
    import core_pkg::*;

    // ctl bit order: [6]reg_write [5]mem_read [4]mem_write [3]mem_to_reg [2]alu_src [1]branch [0]jump
    typedef struct packed {
        logic        rst;
        logic        hold;
        logic        br;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        u1;
        logic        u2;
        logic [6:0]  ctl;
        logic [3:0]  alu;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  ctl;
        logic [3:0]  alu;
    } slot_t;

    typedef struct {
        in_t    in;
        bit     pre_chk;
        bit     pw;
        bit     fl;
        bit     v;
        int     rd;
        int     rs1;
        bit     rw;
        bit     mr;
        int     sc;
        int     fc;
    } vec_t;

    localparam logic [6:0] CTL_ALU = 7'b1000000;
    localparam logic [6:0] CTL_LW  = 7'b1101100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t cur = '0;

    logic        ex_valid, pc_write, if_id_write, if_id_flush;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  c1;
    logic [3:0]  ex_alu_op;
    logic [15:0] stall_count, flush_count;

    logic        v2, pw2, iw2, fl2;
    logic [31:0] pc2, d1_2, d2_2, imm2;
    logic [4:0]  r1_2, r2_2, rd2;
    logic [6:0]  c2;
    logic [3:0]  alu2;
    logic [1:0]  sc2, fc2;

    id_ex_stage_reg dut (
        .clk(clk), .reset(cur.rst), .hold(cur.hold), .ex_branch_taken(cur.br),
        .id_valid(cur.valid), .id_pc(cur.pc), .id_rs1_data(cur.rs1d), .id_rs2_data(cur.rs2d),
        .id_imm(cur.imm), .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_rd(cur.rd),
        .id_uses_rs1(cur.u1), .id_uses_rs2(cur.u2),
        .id_reg_write(cur.ctl[6]), .id_mem_read(cur.ctl[5]), .id_mem_write(cur.ctl[4]),
        .id_mem_to_reg(cur.ctl[3]), .id_alu_src(cur.ctl[2]), .id_branch(cur.ctl[1]),
        .id_jump(cur.ctl[0]), .id_alu_op(cur.alu),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(c1[6]), .ex_mem_read(c1[5]), .ex_mem_write(c1[4]), .ex_mem_to_reg(c1[3]),
        .ex_alu_src(c1[2]), .ex_branch(c1[1]), .ex_jump(c1[0]), .ex_alu_op(ex_alu_op),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(cur.rst), .hold(cur.hold), .ex_branch_taken(cur.br),
        .id_valid(cur.valid), .id_pc(cur.pc), .id_rs1_data(cur.rs1d), .id_rs2_data(cur.rs2d),
        .id_imm(cur.imm), .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_rd(cur.rd),
        .id_uses_rs1(cur.u1), .id_uses_rs2(cur.u2),
        .id_reg_write(cur.ctl[6]), .id_mem_read(cur.ctl[5]), .id_mem_write(cur.ctl[4]),
        .id_mem_to_reg(cur.ctl[3]), .id_alu_src(cur.ctl[2]), .id_branch(cur.ctl[1]),
        .id_jump(cur.ctl[0]), .id_alu_op(cur.alu),
        .ex_valid(v2), .ex_pc(pc2), .ex_rs1_data(d1_2), .ex_rs2_data(d2_2),
        .ex_imm(imm2), .ex_rs1(r1_2), .ex_rs2(r2_2), .ex_rd(rd2),
        .ex_reg_write(c2[6]), .ex_mem_read(c2[5]), .ex_mem_write(c2[4]), .ex_mem_to_reg(c2[3]),
        .ex_alu_src(c2[2]), .ex_branch(c2[1]), .ex_jump(c2[0]), .ex_alu_op(alu2),
        .pc_write(pw2), .if_id_write(iw2), .if_id_flush(fl2),
        .stall_count(sc2), .flush_count(fc2)
    );

    int    checks   = 0;
    int    failures = 0;
    bit    known    = 0;
    slot_t m        = '0;
    int    m_stall  = 0;
    int    m_flush  = 0;
    int    m_stall2 = 0;
    int    m_flush2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: the EX slot is a record; a bubble is an empty record.
    function automatic bit model_load_use(input in_t v);
        return m.valid && m.ctl[5] && (m.rd != 0) && v.valid
               && ((v.u1 && v.rs1 == m.rd) || (v.u2 && v.rs2 == m.rd));
    endfunction

    task automatic model_edge(input in_t v);
        bit lu;
        lu = model_load_use(v);
        if (v.rst) begin
            m = '0; m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
        end else if (v.hold) begin
        end else if (v.br) begin
            m = '0;
            m_flush  = (m_flush  < 65535) ? m_flush  + 1 : m_flush;
            m_flush2 = (m_flush2 < 3)     ? m_flush2 + 1 : m_flush2;
        end else if (lu) begin
            m = '0;
            m_stall  = (m_stall  < 65535) ? m_stall  + 1 : m_stall;
            m_stall2 = (m_stall2 < 3)     ? m_stall2 + 1 : m_stall2;
        end else begin
            m.valid = v.valid;
            m.pc = v.pc; m.rs1d = v.rs1d; m.rs2d = v.rs2d; m.imm = v.imm;
            m.rs1 = v.rs1; m.rs2 = v.rs2; m.rd = v.rd;
            m.ctl = v.valid ? v.ctl : 7'd0;
            m.alu = v.valid ? v.alu : 4'd0;
        end
    endtask

    task automatic check_regs();
        chk("ex_valid", ex_valid, m.valid);
        chk("ex_pc", ex_pc, m.pc);
        chk("ex_rs1_data", ex_rs1_data, m.rs1d);
        chk("ex_rs2_data", ex_rs2_data, m.rs2d);
        chk("ex_imm", ex_imm, m.imm);
        chk("ex_rs1", ex_rs1, m.rs1);
        chk("ex_rs2", ex_rs2, m.rs2);
        chk("ex_rd", ex_rd, m.rd);
        chk("ex_ctl", c1, m.ctl);
        chk("ex_alu_op", ex_alu_op, m.alu);
        chk("stall_count", stall_count, m_stall);
        chk("flush_count", flush_count, m_flush);
        chk("stall_count_w2", sc2, m_stall2);
        chk("flush_count_w2", fc2, m_flush2);
    endtask

    task automatic step(input in_t v, output bit pw_s, output bit fl_s);
        bit lu;
        @(negedge clk);
        cur = v;
        #1;
        pw_s = pc_write;
        fl_s = if_id_flush;
        if (known) begin
            lu = model_load_use(v);
            chk("pc_write", pc_write, !v.hold && !(lu && !v.br));
            chk("if_id_write", if_id_write, !v.hold && !(lu && !v.br));
            chk("if_id_flush", if_id_flush, v.br && !v.hold);
        end
        @(posedge clk);
        model_edge(v);
        known = 1;
        #1;
        check_regs();
    endtask

    function automatic in_t mk(bit rst, bit hld, bit br, bit vld, int rs1, int rs2, int rd,
                               bit u1, bit u2, logic [6:0] ctl);
        in_t r;
        r.rst = rst; r.hold = hld; r.br = br; r.valid = vld;
        r.pc = $urandom; r.rs1d = $urandom; r.rs2d = $urandom; r.imm = $urandom;
        r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
        r.u1 = u1; r.u2 = u2; r.ctl = ctl; r.alu = ALU_ADD;
        return r;
    endfunction

    function automatic vec_t row(in_t i, bit pc, bit pw, bit fl, bit v, int rd, int rs1,
                                 bit rw, bit mr, int sc, int fc);
        vec_t r;
        r.in = i; r.pre_chk = pc; r.pw = pw; r.fl = fl; r.v = v; r.rd = rd; r.rs1 = rs1;
        r.rw = rw; r.mr = mr; r.sc = sc; r.fc = fc;
        return r;
    endfunction

    vec_t vecs[10];
    bit   pw_s, fl_s;
    logic [4:0]  snap_rd;
    logic [15:0] snap_sc;

    initial begin
        //                  rst hld br vld rs1 rs2 rd u1 u2 ctl        pre pw fl  v  rd rs1 rw mr sc fc
        vecs[0] = row(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0),    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1] = row(mk(0, 0, 0, 1, 3, 4, 5, 1, 1, CTL_ALU), 1, 1, 0, 1, 5, 3, 1, 0, 0, 0);
        vecs[2] = row(mk(0, 0, 0, 1, 2, 0, 6, 1, 0, CTL_LW),  1, 1, 0, 1, 6, 2, 1, 1, 0, 0);
        vecs[3] = row(mk(0, 0, 0, 1, 6, 2, 7, 1, 1, CTL_ALU), 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[4] = row(mk(0, 0, 0, 1, 6, 2, 7, 1, 1, CTL_ALU), 1, 1, 0, 1, 7, 6, 1, 0, 1, 0);
        vecs[5] = row(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, CTL_LW),  1, 1, 0, 1, 0, 1, 1, 1, 1, 0);
        vecs[6] = row(mk(0, 0, 0, 1, 0, 0, 8, 1, 1, CTL_ALU), 1, 1, 0, 1, 8, 0, 1, 0, 1, 0);
        vecs[7] = row(mk(0, 0, 0, 1, 1, 0, 9, 1, 0, CTL_LW),  1, 1, 0, 1, 9, 1, 1, 1, 1, 0);
        vecs[8] = row(mk(0, 0, 1, 1, 9, 2, 10, 1, 1, CTL_ALU), 1, 1, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[9] = row(mk(1, 0, 0, 1, 9, 2, 10, 1, 1, CTL_ALU), 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].in, pw_s, fl_s);
            if (vecs[i].pre_chk) begin
                chk($sformatf("vec%0d_pc_write", i), pw_s, vecs[i].pw);
                chk($sformatf("vec%0d_if_id_flush", i), fl_s, vecs[i].fl);
            end
            chk($sformatf("vec%0d_ex_valid", i), ex_valid, vecs[i].v);
            chk($sformatf("vec%0d_ex_rd", i), ex_rd, vecs[i].rd);
            chk($sformatf("vec%0d_ex_rs1", i), ex_rs1, vecs[i].rs1);
            chk($sformatf("vec%0d_ex_reg_write", i), c1[6], vecs[i].rw);
            chk($sformatf("vec%0d_ex_mem_read", i), c1[5], vecs[i].mr);
            chk($sformatf("vec%0d_stall_count", i), stall_count, vecs[i].sc);
            chk($sformatf("vec%0d_flush_count", i), flush_count, vecs[i].fc);
        end

        // Hold for three cycles with a pending hazard and changing ID contents.
        step(mk(0, 0, 0, 1, 2, 0, 6, 1, 0, CTL_LW), pw_s, fl_s);
        snap_rd = ex_rd;
        snap_sc = stall_count;
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 1, (i == 1), 1, 6, i, 11 + i, 1, 1, CTL_ALU), pw_s, fl_s);
            chk("hold_pc_write", pw_s, 1'b0);
            chk("hold_if_id_flush", fl_s, 1'b0);
            chk("hold_ex_rd", ex_rd, snap_rd);
            chk("hold_stall_count", stall_count, snap_sc);
        end
        step(mk(0, 0, 0, 1, 6, 2, 7, 1, 1, CTL_ALU), pw_s, fl_s);
        chk("after_hold_stall", pw_s, 1'b0);

        // Five flushes saturate the 2-bit counter at 3.
        for (int i = 0; i < 5; i++) step(mk(0, 0, 1, 1, 1, 2, 3, 1, 1, CTL_ALU), pw_s, fl_s);
        chk("sat_flush_count_w2", fc2, 2'd3);
        chk("sat_flush_count_w16", flush_count, 16'd5);

        // Reset arriving while a load-use stall is being signalled.
        step(mk(0, 0, 0, 1, 2, 0, 6, 1, 0, CTL_LW), pw_s, fl_s);
        step(mk(1, 0, 0, 1, 6, 2, 7, 1, 1, CTL_ALU), pw_s, fl_s);
        chk("rst_mid_stall_pc_write_before", pw_s, 1'b0);
        chk("rst_mid_stall_ex_valid", ex_valid, 1'b0);
        chk("rst_mid_stall_counts", {stall_count, flush_count}, 32'd0);
        step(mk(0, 0, 0, 1, 6, 2, 7, 1, 1, CTL_ALU), pw_s, fl_s);
        chk("rst_release_pc_write", pw_s, 1'b1);

        // Random traffic with small register numbers so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            in_t r;
            r = mk(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                   ($urandom_range(5) != 0), $urandom_range(3), $urandom_range(3),
                   $urandom_range(3), $urandom_range(1), $urandom_range(1), 7'($urandom));
            r.alu = 4'($urandom);
            step(r, pw_s, fl_s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
